// File: rtl/crc_check_if.sv
// Handshake and result bundle for the serial CRC-16 checker.
// The master drives the bit stream and the slave (crc_check) returns the verdict.
interface crc_check_if;
   logic        start;
   logic        in_valid;
   logic        data;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic [15:0] calc_crc;
   logic [15:0] rx_crc;
   logic [7:0]  err_count;

   modport master (
      output start, in_valid, data,
      input  busy, done, crc_ok, calc_crc, rx_crc, err_count
   );

   modport slave (
      input  start, in_valid, data,
      output busy, done, crc_ok, calc_crc, rx_crc, err_count
   );
endinterface

// File: rtl/crc_check.sv
// Serial CRC-16 checker (x^16+x^15+1, seed FFFF): payload bits, then 16 received CRC bits MSB first.
// Define CRC_CHECK_ERRCNT_EN to build the saturating failed-frame counter; otherwise err_count is 0.
module crc_check #(
   parameter int PAYLOAD_BITS = 32
) (
   input logic        clock,
   input logic        reset_n,
   crc_check_if.slave bus
);

   localparam int CW = 10;

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} state_t;

   state_t          state_reg, state_next;
   logic [15:0]     r_reg, r_next;
   logic [15:0]     rx_reg, rx_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            done_reg, done_next;
   logic            ok_reg, ok_next;
   logic [15:0]     r_step;
   logic [15:0]     rx_shift;
   logic            fb;

   // One Galois step of the LFSR for the current input bit.
   assign fb        = r_reg[15] ^ bus.data;
   assign r_step[0] = fb;
   assign r_step[15] = r_reg[14] ^ fb;
   generate
      for (genvar gi = 1; gi < 15; gi++) begin : g_shift
         assign r_step[gi] = r_reg[gi-1];
      end
   endgenerate

   assign rx_shift = {rx_reg[14:0], bus.data};

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      rx_next    = rx_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      ok_next    = ok_reg;
      // start has priority in every state: it (re)opens a frame and drops any bit offered with it
      if (bus.start) begin
         state_next = PAYLOAD;
         r_next     = 16'hFFFF;
         rx_next    = 16'h0000;
         cnt_next   = CW'(PAYLOAD_BITS);
         ok_next    = 1'b0;
      end else begin
         case (state_reg)
            PAYLOAD: begin
               if (bus.in_valid) begin
                  r_next   = r_step;
                  cnt_next = cnt_reg - CW'(1);
                  if (cnt_reg == CW'(1)) begin
                     state_next = CHECK;
                     cnt_next   = CW'(16);
                  end
               end
            end
            CHECK: begin
               if (bus.in_valid) begin
                  rx_next  = rx_shift;
                  cnt_next = cnt_reg - CW'(1);
                  if (cnt_reg == CW'(1)) begin
                     state_next = DONE;
                     done_next  = 1'b1;
                     ok_next    = (rx_shift == r_reg);
                  end
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         r_reg     <= 16'hFFFF;
         rx_reg    <= 16'h0000;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         ok_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         rx_reg    <= rx_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
         ok_reg    <= ok_next;
      end
   end

`ifdef CRC_CHECK_ERRCNT_EN
   logic [7:0] err_reg;

   // Counts on the same edge that raises done, so the count is current while done is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_reg <= 8'h00;
      end else if (done_next && !ok_next && (err_reg != 8'hFF)) begin
         err_reg <= err_reg + 8'h01;
      end
   end

   assign bus.err_count = err_reg;
`else
   assign bus.err_count = 8'h00;
`endif

   assign bus.busy     = (state_reg == PAYLOAD) || (state_reg == CHECK);
   assign bus.done     = done_reg;
   assign bus.crc_ok   = ok_reg;
   assign bus.calc_crc = r_reg;
   assign bus.rx_crc   = rx_reg;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check (PAYLOAD_BITS=32): vector table, randomized frames with stalls,
// abort, mid-frame reset and error-counter saturation with back-to-back frames.
module tb_crc_check;

   localparam int PB = 32;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_seen = 0;
   logic [7:0] exp_err = 8'h00;

   crc_check_if bus ();

   crc_check #(.PAYLOAD_BITS(PB)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (bus.done) done_seen++;

   typedef struct {
      logic [31:0] payload;
      logic [15:0] crc;
      int          stall_pct;
      logic        exp_ok;
      logic [15:0] exp_calc;
   } vec_t;

   vec_t tbl[8];

   // Reference: CRC as polynomial long division, payload sent MSB first.
   function automatic logic [15:0] model_crc(input logic [31:0] p);
      logic [15:0] r;
      r = 16'hFFFF;
      for (int i = PB - 1; i >= 0; i--) begin
         if (r[15] ^ p[i]) r = (r << 1) ^ 16'h8001;
         else              r = r << 1;
      end
      return r;
   endfunction

   function automatic logic [7:0] bump(input logic [7:0] v);
`ifdef CRC_CHECK_ERRCNT_EN
      return (v == 8'hFF) ? v : v + 8'h01;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.data     = 1'($urandom);
      @(negedge clock);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      chk("seed_loaded", 32'(bus.calc_crc), 32'hFFFF);
      chk("rx_cleared", 32'(bus.rx_crc), 32'h0);
      chk("ok_cleared", 32'(bus.crc_ok), 32'h0);
   endtask

   task automatic send_bits(input int nbits, input logic [47:0] bits, input int stall_pct);
      int early;
      early = 0;
      for (int i = 0; i < nbits; i++) begin
         while ($urandom_range(99) < stall_pct) begin
            bus.in_valid = 1'b0;
            bus.data     = 1'($urandom);
            @(negedge clock);
            if (bus.done) early++;
         end
         bus.in_valid = 1'b1;
         bus.data     = bits[47-i];
         @(negedge clock);
         if (i < nbits - 1 && bus.done) early++;
      end
      bus.in_valid = 1'b0;
      chk("no_early_done", 32'(early), 32'd0);
   endtask

   task automatic run_frame(input logic [31:0] p, input logic [15:0] c, input int stall_pct,
                            input logic chain, input logic exp_ok, input logic [15:0] exp_calc);
      send_bits(48, {p, c}, stall_pct);
      chk("done", 32'(bus.done), 32'd1);
      chk("crc_ok", 32'(bus.crc_ok), 32'(exp_ok));
      chk("calc_crc", 32'(bus.calc_crc), 32'(exp_calc));
      chk("rx_crc", 32'(bus.rx_crc), 32'(c));
      chk("busy_in_done", 32'(bus.busy), 32'd0);
      if (!exp_ok) exp_err = bump(exp_err);
      bus.start    = chain;
      bus.in_valid = 1'b1;
      bus.data     = 1'($urandom);
      @(negedge clock);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("err_count", 32'(bus.err_count), 32'(exp_err));
      if (chain) begin
         chk("busy_chained", 32'(bus.busy), 32'd1);
      end else begin
         chk("crc_ok_hold", 32'(bus.crc_ok), 32'(exp_ok));
         chk("busy_idle", 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] p;
      logic [15:0] good;
      int          d0;

      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.data = 1'b0;

      tbl[0] = '{32'h0, 16'hCCCC, 0, 1'b1, 16'hCCCC};
      tbl[1] = '{32'h0, 16'hCCCD, 0, 1'b0, 16'hCCCC};
      tbl[2] = '{32'h0, 16'hCCCC, 50, 1'b1, 16'hCCCC};
      tbl[3] = '{32'h0, 16'h4CCC, 20, 1'b0, 16'hCCCC};
      for (int k = 4; k < 8; k++) begin
         p    = $urandom;
         good = model_crc(p);
         if (k % 2 == 0) tbl[k] = '{p, good, 40, 1'b1, good};
         else            tbl[k] = '{p, good ^ (16'h1 << $urandom_range(15)), 40, 1'b0, good};
      end

      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_crc_ok", 32'(bus.crc_ok), 32'd0);
      chk("rst_calc", 32'(bus.calc_crc), 32'hFFFF);
      chk("rst_rx", 32'(bus.rx_crc), 32'h0);
      chk("rst_err", 32'(bus.err_count), 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int k = 0; k < 8; k++) begin
         pulse_start();
         run_frame(tbl[k].payload, tbl[k].crc, tbl[k].stall_pct, 1'b0, tbl[k].exp_ok, tbl[k].exp_calc);
         $display("vector %0d: payload=%h crc=%h ok=%b calc=%h", k, tbl[k].payload, tbl[k].crc,
                  bus.crc_ok, bus.calc_crc);
      end

      // Abort in PAYLOAD and in CHECK, then a good frame: exactly one done.
      d0 = done_seen;
      pulse_start();
      send_bits(20, 48'($urandom), 0);
      pulse_start();
      send_bits(40, {$urandom, 16'h0}, 0);
      pulse_start();
      p = $urandom;
      run_frame(p, model_crc(p), 0, 1'b0, 1'b1, model_crc(p));
      chk("abort_single_done", 32'(done_seen - d0), 32'd1);

      // Asynchronous reset in the middle of CHECK.
      pulse_start();
      send_bits(40, {32'h0, 16'hFFFF}, 0);
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_calc", 32'(bus.calc_crc), 32'hFFFF);
      chk("arst_rx", 32'(bus.rx_crc), 32'h0);
      chk("arst_err", 32'(bus.err_count), 32'h0);
      exp_err = 8'h00;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      pulse_start();
      run_frame(32'h0, 16'hCCCC, 0, 1'b0, 1'b1, 16'hCCCC);

      // 257 back-to-back bad frames: counter saturates, start in DONE is taken immediately.
      pulse_start();
      for (int k = 0; k < 257; k++) begin
         p = $urandom;
         run_frame(p, ~model_crc(p), 0, (k < 256), 1'b0, model_crc(p));
      end
`ifdef CRC_CHECK_ERRCNT_EN
      chk("err_saturated", 32'(bus.err_count), 32'hFF);
`else
      chk("err_tied_zero", 32'(bus.err_count), 32'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/crc_check.md
# crc_check

Serial CRC-16 checker: the receive-side counterpart of the team's serial CRC generator. It accepts a frame of PAYLOAD_BITS data bits followed by 16 received CRC bits, recomputes the CRC over the payload, compares it against the received value, and reports pass/fail. It sits on the receive path ahead of the replay-buffer ACK/NAK logic, which consumes `done` and `crc_ok`.

## Interface
- PAYLOAD_BITS, 32: payload bits per frame; legal range 1..1023.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  frame start pulse; loads the CRC seed.
- in_valid  in  1  qualifies `data` for one bit.
- data  in  1  serial bit: payload first, then CRC MSB first.
- busy  out  1  high in PAYLOAD and CHECK.
- done  out  1  one-cycle pulse when the verdict is valid.
- crc_ok  out  1  verdict: received CRC equals computed CRC; held until next `start`.
- calc_crc  out  16  computed CRC, frozen after the last payload bit.
- rx_crc  out  16  received CRC, assembled MSB first.
- err_count  out  8  saturating count of failed frames (see Configuration).

## Operation
- CRC update per accepted payload bit d: fb = r[15]^d; r[15] <= r[14]^fb; r[14:1] <= r[13:0]; r[0] <= fb. The polynomial is x^16+x^15+1 and the seed is 16'hFFFF.
- State IDLE:
  - `start` → PAYLOAD; r <= 16'hFFFF; bit counter <= PAYLOAD_BITS; rx_crc <= 0; crc_ok <= 0.
- State PAYLOAD:
  - Each cycle with in_valid=1 updates r and decrements the counter.
  - When the bit accepted with the counter at 1 is taken → CHECK; counter <= 16.
  - Cycles with in_valid=0 are stalls; all state holds.
- State CHECK:
  - Each cycle with in_valid=1 performs rx_crc <= {rx_crc[14:0], data} and decrements the counter.
  - After the 16th bit → DONE.
  - r is not updated in CHECK.
- State DONE (one cycle):
  - done=1; crc_ok = (rx_crc == r); err_count increments if the frame failed.
  - Next state is IDLE, or PAYLOAD if `start` is high in this cycle, with the same loads as in IDLE.
- `start` in PAYLOAD or CHECK aborts the current frame and restarts it (seed reloaded). The aborted frame produces no `done` pulse and no err_count change.
- in_valid is ignored in IDLE and DONE.
- calc_crc = r at all times.

## Timing
- Reset values: state IDLE, r=16'hFFFF, rx_crc=0, counter=0, busy=0, done=0, crc_ok=0, err_count=0. Reset asserted mid-frame discards the frame immediately.
- `start` sampled at edge N → busy=1 from N. The first bit can be accepted at edge N+1.
- With no stalls, `done` pulses exactly PAYLOAD_BITS+16 cycles after the `start` edge, i.e. in the cycle following the last CRC bit.
- `start` together with in_valid in the same IDLE cycle: the start is taken and the bit is dropped.
- `done` and `crc_ok` are registered and glitch-free. crc_ok holds its value after `done` until the next `start` is accepted.
- err_count saturates at 8'hFF and does not wrap.

## Configuration
- CRC_CHECK_ERRCNT_EN:
  - Defined: err_count is implemented as described.
  - Undefined: the counter logic is removed and err_count is tied to 8'h00. All other behaviour is identical.

## Test plan
- PAYLOAD_BITS=32, 32 zero bits, then CRC 16'hCCCC, no stalls → done pulses 48 cycles after start, crc_ok=1, calc_crc=16'hCCCC, err_count=0.
- PAYLOAD_BITS=16, 16 zero bits, then CRC 16'hAAAB → crc_ok=0, calc_crc=16'hAAAA, rx_crc=16'hAAAB, err_count=1. With the macro undefined, err_count=0.
- Same good frame as the first scenario with in_valid deasserted on random cycles (~50%) → identical verdict, crc_ok=1. done arrives after exactly 48 accepted bits.
- `start` re-asserted after 20 payload bits, then a full good frame → exactly one done pulse, crc_ok=1, err_count unchanged.
- reset_n pulsed low mid-CHECK → all outputs return to reset values in the same cycle. A following good frame passes.
- 257 consecutive bad frames (macro defined) → err_count holds at 8'hFF. A back-to-back `start` in the DONE cycle is accepted with no idle gap.
